// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Default sizing constants for the pipelined-CPU register file and a helper
//   that derives the register address width from the register count.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 32;

    // Address width for a given register count; never narrower than one bit.
    function automatic int unsigned rf_addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   Pending-write tracker for the register file. One busy bit per register is
//   set when decode issues an instruction targeting that register and cleared
//   when writeback retires it, or all at once on a pipeline flush. A read-after-
//   write hazard is raised when either source register is still pending and is
//   not being written back in the current cycle.
//
//   Ports:
//     clk_i         in   clock, rising edge
//     rst_n         in   asynchronous active-low reset
//     issue_i       in   decode issues a writer of issue_addr_i
//     issue_addr_i  in   destination of the issued instruction
//     flush_i       in   clear every pending bit
//     wr_en_i       in   writeback enable
//     wr_addr_i     in   writeback address
//     r1_addr_i     in   source register 1
//     r2_addr_i     in   source register 2
//     hazard_o      out  a source register has an unresolved pending write
//     busy_o        out  pending-write bit per register
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = rf_addr_w(NUM_REGS),
    parameter bit          ZERO_R0  = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                issue_i,
    input  logic [ADDR_W-1:0]   issue_addr_i,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [ADDR_W-1:0]   r1_addr_i,
    input  logic [ADDR_W-1:0]   r2_addr_i,
    output logic                hazard_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                pend1;
    logic                pend2;

    // Priority per bit: flush clears, then issue sets, then writeback clears.
    // Issue outranks writeback so that a new producer issued in the same cycle
    // as the old one retires keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (issue_i && (issue_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        // Register 0 never has a producer when it is hardwired to zero.
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A source being written back this cycle is served by forwarding, so its
    // pending bit must not stall decode.
    always_comb begin
        pend1    = busy_q[r1_addr_i] & ~(wr_en_i && (wr_addr_i == r1_addr_i));
        pend2    = busy_q[r2_addr_i] & ~(wr_en_i && (wr_addr_i == r2_addr_i));
        hazard_o = pend1 | pend2;
    end

    assign busy_o = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Register file for the pipelined CPU: two combinational read ports, one
//   synchronous write port with same-cycle write-to-read forwarding, optional
//   hardwired-zero register 0, and a pending-write scoreboard that drives a
//   read-after-write hazard signal to decode.
//
//   Ports:
//     clk_i         in   clock, all state updates on the rising edge
//     rst_n         in   asynchronous active-low reset
//     RegWrite_i    in   writeback enable
//     w1_addr_i     in   writeback address
//     w1_data_i     in   writeback data
//     r1_addr_i     in   read port 1 address
//     r2_addr_i     in   read port 2 address
//     r1_data_o     out  read port 1 data (combinational)
//     r2_data_o     out  read port 2 data (combinational)
//     issue_i       in   decode issues an instruction that writes issue_addr_i
//     issue_addr_i  in   destination of the issued instruction
//     flush_i       in   clear all pending bits
//     hazard_o      out  a source register has an unresolved pending write
//     busy_o        out  pending-write bit per register
// -----------------------------------------------------------------------------
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = rf_addr_w(NUM_REGS),
    parameter bit          ZERO_R0  = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                RegWrite_i,
    input  logic [ADDR_W-1:0]   w1_addr_i,
    input  logic [DATA_W-1:0]   w1_data_i,
    input  logic [ADDR_W-1:0]   r1_addr_i,
    input  logic [ADDR_W-1:0]   r2_addr_i,
    output logic [DATA_W-1:0]   r1_data_o,
    output logic [DATA_W-1:0]   r2_data_o,
    input  logic                issue_i,
    input  logic [ADDR_W-1:0]   issue_addr_i,
    input  logic                flush_i,
    output logic                hazard_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;
    logic              r1_is_zero;
    logic              r2_is_zero;

    // Effective write: a write to the hardwired-zero register is dropped, which
    // also keeps it out of the forwarding path below.
    assign wr_en      = RegWrite_i && !(ZERO_R0 && (w1_addr_i == '0));
    assign r1_is_zero = ZERO_R0 && (r1_addr_i == '0);
    assign r2_is_zero = ZERO_R0 && (r2_addr_i == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[w1_addr_i] = w1_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: zero register, then forwarded writeback data, then the array.
    // Everything is masked while reset is asserted so that forwarded data
    // cannot leak out during reset.
    always_comb begin
        r1_data_o = '0;
        if (rst_n && !r1_is_zero) begin
            if (wr_en && (w1_addr_i == r1_addr_i)) begin
                r1_data_o = w1_data_i;
            end else begin
                r1_data_o = regs_q[r1_addr_i];
            end
        end
    end

    always_comb begin
        r2_data_o = '0;
        if (rst_n && !r2_is_zero) begin
            if (wr_en && (w1_addr_i == r2_addr_i)) begin
                r2_data_o = w1_data_i;
            end else begin
                r2_data_o = regs_q[r2_addr_i];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_R0  (ZERO_R0)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .wr_en_i      (RegWrite_i),
        .wr_addr_i    (w1_addr_i),
        .r1_addr_i    (r1_addr_i),
        .r2_addr_i    (r2_addr_i),
        .hazard_o     (hazard_o),
        .busy_o       (busy_o)
    );

endmodule : reg_file_sb

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the processor's 32x32 register file for the pipelined CPU. It provides two combinational read ports and one synchronous write port with same-cycle write-to-read forwarding. An optional hardwired-zero register 0 and a per-register pending-write scoreboard drive a read-after-write hazard/stall signal to the decode stage. It sits between instruction decode (reads, issue) and writeback (write).

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register address width
- ZERO_R0, 1, 1: register 0 reads as zero, ignores writes, never busy

- clk_i  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWrite_i  in  1  writeback enable
- w1_addr_i  in  ADDR_W  writeback address
- w1_data_i  in  DATA_W  writeback data
- r1_addr_i  in  ADDR_W  read port 1 address
- r2_addr_i  in  ADDR_W  read port 2 address
- r1_data_o  out  DATA_W  read port 1 data (combinational)
- r2_data_o  out  DATA_W  read port 2 data (combinational)
- issue_i  in  1  decode issues an instruction that will write issue_addr_i
- issue_addr_i  in  ADDR_W  destination of the issued instruction
- flush_i  in  1  synchronous clear of all pending bits (pipeline flush)
- hazard_o  out  1  a source register has an unresolved pending write
- busy_o  out  NUM_REGS  pending-write bit per register

## Operation
- Storage: NUM_REGS x DATA_W array plus a NUM_REGS-bit busy vector.
- Write: on a rising edge with RegWrite_i=1, reg[w1_addr_i] <= w1_data_i. When ZERO_R0=1 and w1_addr_i=0, there is no write.
- Read port k: if RegWrite_i=1, w1_addr_i=rk_addr_i, and the address is not the ZERO_R0 register, the output is w1_data_i (forwarding). Otherwise the output is reg[rk_addr_i]. With ZERO_R0=1, rk_addr_i=0 always reads 0.
- Scoreboard, per register i, at each rising edge, in priority order:
  - flush_i=1 clears the bit. The write still happens.
  - Otherwise, issue_i=1 with issue_addr_i=i sets the bit.
  - Otherwise, RegWrite_i=1 with w1_addr_i=i clears the bit.
  - Issue and write to the same register in the same cycle: the bit ends set, because the new producer wins.
  - With ZERO_R0=1, bit 0 is held at 0 and issue to register 0 is ignored.
- hazard_o = pend(r1) | pend(r2), where pend(a) = busy[a] & ~(RegWrite_i & w1_addr_i==a). A register being written this cycle is covered by forwarding and does not raise hazard_o.
- Reset (asynchronous, any time, including mid-write): all registers 0 and busy_o=0. As a result hazard_o=0, and r1_data_o/r2_data_o=0 while reset is asserted, since forwarded data is masked by rst_n=0.

## Timing
- Read latency is 0 cycles (combinational from addresses, RegWrite_i, w1_*).
- Write is visible through forwarding in the same cycle and from the array on the next cycle.
- busy_o updates one edge after issue_i or writeback. hazard_o is combinational from busy_o, the read addresses and the writeback signals.
- Back-to-back writes to the same address on consecutive cycles: the last one wins; no lost write.
- Deassertion of rst_n is taken synchronously to clk_i by the surrounding design. The block requires no edge during the deassertion cycle.

## Structure
- Package reg_file_pkg holds the default constants (DATA_W, NUM_REGS) and a localparam function for ADDR_W. The block has no typedefs beyond those.
- Sub-module reg_scoreboard holds the busy vector, the set/clear/flush priority, and the hazard_o logic. The top level holds the array, forwarding and zero masking.

## Test plan
- Reset: hold rst_n=0 with RegWrite_i=1, w1_addr=3, w1_data=0xFFFF_FFFF → r1_data_o=0, busy_o=0, hazard_o=0. Release and read every address → all 0.
- Write/forward: RegWrite=1, w1_addr=5, w1_data=0x1234_5678, r1_addr=5 in the same cycle → r1_data_o=0x1234_5678 before the edge. After the edge, with RegWrite=0, it still reads 0x1234_5678.
- Zero register: write 0xDEAD_BEEF to address 0 → r1_data_o=0 with ZERO_R0=1. Repeat with ZERO_R0=0 → reads 0xDEAD_BEEF next cycle.
- Hazard: issue_i=1, issue_addr=7; next cycle r2_addr=7 → hazard_o=1, busy_o[7]=1. Writeback to 7 with data 0x42 → hazard_o=0 that cycle and r2_data_o=0x42. busy_o[7]=0 after the edge.
- Simultaneous: issue to 9 and write to 9 in the same cycle → busy_o[9]=1 after the edge. flush_i=1 with busy bits {2,9} set → busy_o=0 after the edge, and the concurrent write to 4 still lands.
- Parameter sweep: DATA_W=16, NUM_REGS=8 → 3-bit addresses. Writing 0xABCD to register 7 reads back 0xABCD, and registers 0–6 are unaffected.
